// File: rtl/chan_cfg_pkg.sv
// chan_cfg_pkg: shared types and constants for the channelizer settings sequencer.
//   - cfg_state_e : reload FSM state encoding (value also reported in status)
//   - Sr*         : default settings-bus addresses
//   - Status*Lsb  : field offsets inside the 32-bit status word
package chan_cfg_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDrain  = 2'd1,
    StLoad   = 2'd2,
    StCommit = 2'd3
  } cfg_state_e;

  localparam logic [7:0] SrCfgCtrl    = 8'd140;
  localparam logic [7:0] SrCoefData   = 8'd141;
  localparam logic [7:0] SrCoefCommit = 8'd142;

  localparam int unsigned StatusTapLsb    = 0;
  localparam int unsigned StatusStateLsb  = 16;
  localparam int unsigned StatusErrCntLsb = 24;

endpackage

// File: rtl/chan_cfg_drain_timer.sv
// chan_cfg_drain_timer: load/count/expire counter bounding the DRAIN wait.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : clear the count (held while not draining)
//   count      : advance one cycle of waiting
//   expired    : high in the cycle that completes Limit counted cycles
module chan_cfg_drain_timer
  import chan_cfg_pkg::*;
#(
  parameter int unsigned Limit = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic expired
);

  localparam int unsigned CntW = $clog2(Limit + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired = count && (cnt_q == CntW'(Limit - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (load || expired) begin
      cnt_d = '0;
    end else if (count) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/chan_cfg_sequencer.sv
// chan_cfg_sequencer: settings-bus controller in front of the channelizer.
// Forwards host settings writes, and on command gates the sample stream, drains it,
// reloads the polyphase coefficient table from s_coef_* and commits it.
// Ports:
//   ce_clk, ce_rst_n                      : clock, asynchronous active-low reset
//   set_stb/set_addr/set_data             : host settings bus in
//   chan_set_stb/chan_set_addr/chan_set_data : registered settings bus to the channelizer
//   s_coef_tdata/tvalid/tlast/tready      : coefficient stream
//   chan_idle                             : channelizer has nothing in flight
//   data_gate, busy, done, err, status    : control / status outputs
// Build option: define CHAN_CFG_TIMEOUT_EN to abort DRAIN after DRAIN_TIMEOUT cycles.
module chan_cfg_sequencer
  import chan_cfg_pkg::*;
#(
  parameter int unsigned NUM_TAPS       = 1024,
  parameter int unsigned COEF_W         = 18,
  parameter logic [7:0]  SR_CFG_CTRL    = SrCfgCtrl,
  parameter logic [7:0]  SR_COEF_DATA   = SrCoefData,
  parameter logic [7:0]  SR_COEF_COMMIT = SrCoefCommit,
  parameter int unsigned DRAIN_TIMEOUT  = 4096
) (
  input  logic        ce_clk,
  input  logic        ce_rst_n,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  output logic        chan_set_stb,
  output logic [7:0]  chan_set_addr,
  output logic [31:0] chan_set_data,
  input  logic [31:0] s_coef_tdata,
  input  logic        s_coef_tvalid,
  input  logic        s_coef_tlast,
  output logic        s_coef_tready,
  input  logic        chan_idle,
  output logic        data_gate,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] status
);

  localparam int unsigned IDX_W = $clog2(NUM_TAPS);

  cfg_state_e  state_q, state_d;
  logic [15:0] tap_q, tap_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        stb_q, stb_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        ctrl_wr, host_fwd, start, abort, beat, drain_expired, raise_err;
  logic [31:0] coef_word;

  assign ctrl_wr  = set_stb && (set_addr == SR_CFG_CTRL);
  assign host_fwd = set_stb && (set_addr != SR_CFG_CTRL);
  assign start    = ctrl_wr && set_data[0];
  assign abort    = ctrl_wr && set_data[1];

  // Host writes own the channelizer port, so the stream stalls while one is pending.
  assign s_coef_tready = (state_q == StLoad) && !host_fwd;
  assign beat          = s_coef_tvalid && s_coef_tready;

  always_comb begin
    coef_word                      = '0;
    coef_word[COEF_W-1:0]          = s_coef_tdata[COEF_W-1:0];
    coef_word[COEF_W +: IDX_W]     = tap_q[IDX_W-1:0];
  end

`ifdef CHAN_CFG_TIMEOUT_EN
  chan_cfg_drain_timer #(
    .Limit (DRAIN_TIMEOUT)
  ) u_drain_timer (
    .clk     (ce_clk),
    .rst_n   (ce_rst_n),
    .load    (state_q != StDrain),
    .count   ((state_q == StDrain) && !chan_idle),
    .expired (drain_expired)
  );
`else
  assign drain_expired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    err_cnt_d = err_cnt_q;
    stb_d     = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    raise_err = 1'b0;

    if (host_fwd) begin
      stb_d  = 1'b1;
      addr_d = set_addr;
      data_d = set_data;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StDrain;
          tap_d   = '0;
        end
      end
      StDrain: begin
        if (abort || drain_expired) begin
          state_d   = StIdle;
          raise_err = 1'b1;
        end else if (chan_idle) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (beat) begin
          stb_d  = 1'b1;
          addr_d = SR_COEF_DATA;
          data_d = coef_word;
          tap_d  = tap_q + 16'd1;
          if (tap_q == 16'(NUM_TAPS - 1)) begin
            state_d = StCommit;
          end else if (s_coef_tlast) begin
            state_d   = StIdle;
            raise_err = 1'b1;
          end
        end
        if (abort) begin
          state_d   = StIdle;
          raise_err = 1'b1;
        end
      end
      StCommit: begin
        if (abort) begin
          state_d   = StIdle;
          raise_err = 1'b1;
        end else if (!host_fwd) begin
          stb_d   = 1'b1;
          addr_d  = SR_COEF_COMMIT;
          data_d  = 32'(NUM_TAPS);
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (raise_err) begin
      err_d = 1'b1;
      if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      state_q   <= StIdle;
      tap_q     <= '0;
      err_cnt_q <= '0;
      stb_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      err_cnt_q <= err_cnt_d;
      stb_q     <= stb_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign chan_set_stb  = stb_q;
  assign chan_set_addr = addr_q;
  assign chan_set_data = data_q;
  assign done          = done_q;
  assign err           = err_q;
  assign busy          = (state_q != StIdle);
  assign data_gate     = (state_q != StIdle);

  always_comb begin
    status                               = '0;
    status[StatusErrCntLsb +: 8]         = err_cnt_q;
    status[StatusStateLsb +: 2]          = state_q;
    status[StatusTapLsb +: 16]           = tap_q;
  end

  // Coefficient bits above COEF_W and control bits above [1] carry no meaning.
  logic unused_bits;
  assign unused_bits = ^{s_coef_tdata[31:COEF_W], set_data[31:2]};

endmodule

// File: tb/tb_chan_cfg_sequencer.sv
// tb_chan_cfg_sequencer: randomized self-checking bench for chan_cfg_sequencer.
// Expected channelizer writes are queued by a transaction-level model and matched in order.
module tb_chan_cfg_sequencer;

  localparam int NumTaps = 1024;

  logic        ce_clk, ce_rst_n;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic        chan_set_stb;
  logic [7:0]  chan_set_addr;
  logic [31:0] chan_set_data;
  logic [31:0] s_coef_tdata;
  logic        s_coef_tvalid, s_coef_tlast, s_coef_tready;
  logic        chan_idle, data_gate, busy, done, err;
  logic [31:0] status;

  chan_cfg_sequencer u_dut (
    .ce_clk        (ce_clk),
    .ce_rst_n      (ce_rst_n),
    .set_stb       (set_stb),
    .set_addr      (set_addr),
    .set_data      (set_data),
    .chan_set_stb  (chan_set_stb),
    .chan_set_addr (chan_set_addr),
    .chan_set_data (chan_set_data),
    .s_coef_tdata  (s_coef_tdata),
    .s_coef_tvalid (s_coef_tvalid),
    .s_coef_tlast  (s_coef_tlast),
    .s_coef_tready (s_coef_tready),
    .chan_idle     (chan_idle),
    .data_gate     (data_gate),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .status        (status)
  );

  initial ce_clk = 1'b0;
  always #5 ce_clk = ~ce_clk;

  int n_checks = 0;
  int n_fails  = 0;
  int done_seen = 0;
  int err_seen  = 0;
  int exp_done  = 0;
  int exp_err   = 0;
  logic [39:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [39:0] coef_wr(input int idx, input logic [31:0] coef);
    logic [31:0] w;
    w        = '0;
    w[17:0]  = coef[17:0];
    w[27:18] = idx[9:0];
    return {8'd141, w};
  endfunction

  task automatic tick();
    @(posedge ce_clk);
    #1;
  endtask

  // Monitor: every channelizer write must be the next one the model predicted.
  always @(negedge ce_clk) begin
    if (ce_rst_n) begin
      if (chan_set_stb) begin
        check_eq("wr_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          check_eq("wr_content", {chan_set_addr, chan_set_data}, exp_q.pop_front());
        end
      end
      if (done) begin
        done_seen++;
        check_eq("done_with_commit", {chan_set_stb, chan_set_addr}, {1'b1, 8'd142});
        check_eq("done_gate_low", data_gate, 1'b0);
      end
      if (err) err_seen++;
    end
  end

  task automatic start_reload();
    set_stb  = 1'b1;
    set_addr = 8'd140;
    set_data = 32'd1;
    tick();
    set_stb = 1'b0;
    check_eq("start_gate", {data_gate, busy, s_coef_tready}, 3'b110);
    tick();
  endtask

  // Feed beats k0..kend-1; a model beat is accepted when valid and no host write is pending.
  task automatic feed(input int k0, input int kend, input int last_at, input bit rnd,
                      input bit host);
    int k;
    int guard;
    bit hw;
    logic [31:0] c;
    k = k0;
    guard = 0;
    while (k < kend && guard < 20000) begin
      hw = host && ($urandom_range(0, 5) == 0);
      c  = rnd ? $urandom : 32'(k);
      set_stb = hw;
      if (hw) begin
        set_addr = 8'($urandom_range(0, 139));
        set_data = $urandom;
      end
      s_coef_tvalid = ($urandom_range(0, 3) != 0);
      s_coef_tdata  = c;
      s_coef_tlast  = (k == last_at);
      #1;
      check_eq("tready_arb", s_coef_tready, !hw);
      if (hw) exp_q.push_back({set_addr, set_data});
      if (s_coef_tvalid && !hw) begin
        exp_q.push_back(coef_wr(k, c));
        k++;
      end
      tick();
      guard++;
    end
    set_stb       = 1'b0;
    s_coef_tvalid = 1'b0;
    s_coef_tlast  = 1'b0;
    check_eq("feed_bound", 64'(k), 64'(kend));
  endtask

  logic [7:0] ha;
  int cyc;
  int err_before;

  initial begin
    ce_rst_n      = 1'b0;
    set_stb       = 1'b0;
    set_addr      = '0;
    set_data      = '0;
    s_coef_tdata  = '0;
    s_coef_tvalid = 1'b0;
    s_coef_tlast  = 1'b0;
    chan_idle     = 1'b1;
    repeat (3) tick();
    check_eq("rst_outs", {chan_set_stb, chan_set_addr, chan_set_data, s_coef_tready,
                          data_gate, busy, done, err}, '0);
    check_eq("rst_status", status, '0);
    ce_rst_n = 1'b1;
    tick();

    // Host forwarding in IDLE, and the control address is swallowed.
    set_stb  = 1'b1;
    set_addr = 8'd128;
    set_data = 32'h1234;
    exp_q.push_back({8'd128, 32'h1234});
    tick();
    set_stb = 1'b0;
    check_eq("fwd_n1", {chan_set_stb, chan_set_addr, chan_set_data}, {1'b1, 8'd128, 32'h1234});
    tick();
    check_eq("fwd_once", chan_set_stb, 1'b0);
    set_stb  = 1'b1;
    set_addr = 8'd140;
    set_data = 32'd0;
    tick();
    set_stb = 1'b0;
    check_eq("ctrl_not_fwd", {chan_set_stb, busy}, 2'b00);

    // Full reload, coef = index, no host traffic; commit two cycles after last beat.
    start_reload();
    feed(0, NumTaps, NumTaps - 1, 1'b0, 1'b0);
    check_eq("last_beat_state", {busy, data_gate, done}, 3'b110);
    exp_q.push_back({8'd142, 32'd1024});
    tick();
    check_eq("commit_n2", {done, data_gate, busy, chan_set_stb, chan_set_addr, chan_set_data},
             {1'b1, 1'b0, 1'b0, 1'b1, 8'd142, 32'd1024});
    exp_done++;
    tick();
    check_eq("done_one_cycle", done, 1'b0);

    // Full reload with random coefs and host traffic, host write colliding with commit.
    start_reload();
    feed(0, NumTaps, NumTaps - 1, 1'b1, 1'b1);
    ha       = 8'($urandom_range(0, 139));
    set_stb  = 1'b1;
    set_addr = ha;
    set_data = $urandom;
    exp_q.push_back({ha, set_data});
    exp_q.push_back({8'd142, 32'd1024});
    tick();
    set_stb = 1'b0;
    check_eq("commit_deferred", {done, busy, chan_set_addr}, {1'b0, 1'b1, ha});
    tick();
    check_eq("commit_n3", {done, data_gate}, 2'b10);
    exp_done++;
    tick();

    // Early tlast on beat 10: beat written, error, no commit.
    start_reload();
    feed(0, 11, 10, 1'b1, 1'b1);
    check_eq("early_last_err", {err, busy, data_gate}, 3'b100);
    exp_err++;
    repeat (3) tick();
    check_eq("status_errcnt", status[31:24], 8'd1);
    check_eq("status_state_idle", status[17:16], 2'd0);
    check_eq("sb_empty_tlast", 64'(exp_q.size()), 64'd0);

    // Drain with chan_idle held low.
    chan_idle  = 1'b0;
    err_before = err_seen;
    start_reload();
`ifdef CHAN_CFG_TIMEOUT_EN
    cyc = 0;
    while (err_seen == err_before && cyc < 5000) begin
      tick();
      cyc++;
    end
    exp_err++;
    check_eq("timeout_window", 64'((cyc >= 4090) && (cyc <= 4105)), 64'd1);
    check_eq("timeout_idle", busy, 1'b0);
`else
    repeat (10000) tick();
    check_eq("drain_no_err", 64'(err_seen - err_before), 64'd0);
    check_eq("drain_hold", {busy, data_gate, status[17:16]}, {1'b1, 1'b1, 2'd1});
    set_stb  = 1'b1;
    set_addr = 8'd140;
    set_data = 32'd2;
    tick();
    set_stb = 1'b0;
    check_eq("drain_abort", {err, busy}, 2'b10);
    exp_err++;
`endif
    chan_idle = 1'b1;
    repeat (2) tick();

    // Reset mid-LOAD, then a fresh reload starts at tap 0 and is aborted.
    start_reload();
    feed(0, 300, -1, 1'b1, 1'b1);
    ce_rst_n = 1'b0;
    #1;
    check_eq("rst_mid_outs", {chan_set_stb, chan_set_addr, chan_set_data, s_coef_tready,
                              data_gate, busy, done, err, status}, '0);
    exp_q.delete();
    repeat (3) tick();
    check_eq("rst_hold_outs", {chan_set_stb, s_coef_tready, data_gate, busy, done, err, status},
             '0);
    ce_rst_n = 1'b1;
    tick();
    start_reload();
    feed(0, 5, -1, 1'b1, 1'b0);
    set_stb       = 1'b1;
    set_addr      = 8'd140;
    set_data      = 32'd1;
    s_coef_tvalid = 1'b0;
    #1;
    check_eq("tready_ctrl_wr", s_coef_tready, 1'b1);
    tick();
    set_stb = 1'b0;
    check_eq("start_ignored", {busy, chan_set_stb}, 2'b10);
    feed(5, 12, -1, 1'b1, 1'b0);
    set_stb  = 1'b1;
    set_addr = 8'd140;
    set_data = 32'd2;
    tick();
    set_stb = 1'b0;
    check_eq("abort_err", {err, busy, data_gate}, 3'b100);
    exp_err++;
    repeat (5) tick();
    check_eq("abort_errcnt", status[31:24], 8'd1);

    repeat (5) tick();
    check_eq("sb_empty_end", 64'(exp_q.size()), 64'd0);
    check_eq("done_total", 64'(done_seen), 64'(exp_done));
    check_eq("err_total", 64'(err_seen), 64'(exp_err));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
